// File: rtl/btn_toggle_ctrl.sv
// Button front-end for the LED blinker: two raw buttons are synchronised, debounced
// and turned into press strobes that toggle the held enable/speed levels.

module btn_debounce #(
  parameter int DEBOUNCE = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } state_t;

  logic [1:0]       sync;
  logic             s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pulse_nxt;

  assign s = sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= 2'b00;
      state <= RELEASED;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pulse <= pulse_nxt;
    end
  end

  // Each CHK state needs DEBOUNCE consecutive agreeing samples before committing;
  // any disagreeing sample drops back to the previous stable state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    case (state)
      RELEASED: begin
        if (s) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = '0;
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = PRESSED;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_nxt = RELEASE_CHK;
          cnt_nxt   = '0;
        end
      end
      RELEASE_CHK: begin
        if (s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = RELEASED;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

module btn_toggle_ctrl #(
  parameter int DEBOUNCE = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_en,
  input  logic btn_speed,
  output logic en,
  output logic speed,
  output logic en_pulse,
  output logic speed_pulse
);

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_en (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_en),
    .pulse (en_pulse)
  );

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_speed (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_speed),
    .pulse (speed_pulse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      en    <= 1'b0;
      speed <= 1'b0;
    end else begin
      en    <= en ^ en_pulse;
      speed <= speed ^ speed_pulse;
    end
  end

endmodule

// File: tb/tb_btn_toggle_ctrl.sv
// Directed bench for btn_toggle_ctrl with DEBOUNCE=4; a run-length model of the
// debounced button level is compared against the DUT on every cycle.

module tb_btn_toggle_ctrl;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_en = 1'b0;
  logic btn_speed = 1'b0;
  logic en;
  logic speed;
  logic en_pulse;
  logic speed_pulse;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  btn_toggle_ctrl #(.DEBOUNCE(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_en      (btn_en),
    .btn_speed   (btn_speed),
    .en          (en),
    .speed       (speed),
    .en_pulse    (en_pulse),
    .speed_pulse (speed_pulse)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%b required=%b at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change on the falling edge and are held for n cycles.
  task automatic applyStimulus(input logic e, input logic s, input int n);
    btn_en    = e;
    btn_speed = s;
    repeat (n) @(negedge clk);
  endtask

  // Model: a button's debounced level flips once the synchronised input has
  // disagreed with it for D+1 consecutive edges; a 0->1 flip yields one pulse.
  bit [1:0] m_sync  [2] = '{2'b00, 2'b00};
  bit       m_level [2] = '{1'b0, 1'b0};
  int       m_run   [2] = '{0, 0};
  bit       m_pulse [2] = '{1'b0, 1'b0};
  bit       m_out   [2] = '{1'b0, 1'b0};
  bit       m_raw   [2];

  always @(posedge clk) begin
    m_raw[0] = btn_en;
    m_raw[1] = btn_speed;
    for (int b = 0; b < 2; b++) begin
      if (rst) begin
        m_sync[b]  = 2'b00;
        m_level[b] = 1'b0;
        m_run[b]   = 0;
        m_pulse[b] = 1'b0;
        m_out[b]   = 1'b0;
      end else begin
        m_out[b]   = m_out[b] ^ m_pulse[b];
        m_pulse[b] = 1'b0;
        if (m_sync[b][1] != m_level[b]) begin
          m_run[b]++;
          if (m_run[b] == D + 1) begin
            m_level[b] = m_sync[b][1];
            m_run[b]   = 0;
            m_pulse[b] = m_level[b];
          end
        end else begin
          m_run[b] = 0;
        end
        m_sync[b] = {m_sync[b][0], m_raw[b]};
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      checkOutput("cyc_en", en, m_out[0]);
      checkOutput("cyc_speed", speed, m_out[1]);
      checkOutput("cyc_en_pulse", en_pulse, m_pulse[0]);
      checkOutput("cyc_speed_pulse", speed_pulse, m_pulse[1]);
    end
  end

  initial begin
    // Reset with buttons idle, then 20 quiet cycles
    rst = 1'b1;
    @(negedge clk);
    cmp_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("reset_en", en, 1'b0);
      checkOutput("reset_speed", speed, 1'b0);
      checkOutput("reset_en_pulse", en_pulse, 1'b0);
      checkOutput("reset_speed_pulse", speed_pulse, 1'b0);
    end

    // Clean press: pulse after edge t0+6, level after edge t0+7
    applyStimulus(1'b1, 1'b0, 6);
    checkOutput("clean_no_early_pulse", en_pulse, 1'b0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("clean_pulse", en_pulse, 1'b1);
    checkOutput("clean_en_before_flip", en, 1'b0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("clean_pulse_one_cycle", en_pulse, 1'b0);
    checkOutput("clean_en_flip", en, 1'b1);
    applyStimulus(1'b1, 1'b0, 4);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("clean_en_held", en, 1'b1);
    checkOutput("clean_speed_idle", speed, 1'b0);
    applyStimulus(1'b1, 1'b0, 7);
    checkOutput("clean2_pulse", en_pulse, 1'b1);
    applyStimulus(1'b1, 1'b0, 5);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("clean2_en_back", en, 1'b0);
    checkOutput("clean2_speed_idle", speed, 1'b0);

    // Press bounce on speed, then a stable press
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1'b0, 1'b1, 3);
      applyStimulus(1'b0, 1'b0, 1);
    end
    checkOutput("bounce_speed_still0", speed, 1'b0);
    applyStimulus(1'b0, 1'b1, 6);
    checkOutput("bounce_no_early_pulse", speed_pulse, 1'b0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("bounce_pulse", speed_pulse, 1'b1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("bounce_speed", speed, 1'b1);
    applyStimulus(1'b0, 1'b1, 4);
    applyStimulus(1'b0, 1'b0, 12);

    // Release bounce on en
    applyStimulus(1'b1, 1'b0, 12);
    checkOutput("relbounce_en_on", en, 1'b1);
    for (int r = 0; r < 2; r++) begin
      applyStimulus(1'b0, 1'b0, 2);
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 1);
    end
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("relbounce_en_kept", en, 1'b1);
    checkOutput("relbounce_speed_kept", speed, 1'b1);

    // Simultaneous presses from a fresh reset
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 2);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("sim_en_reset", en, 1'b0);
    checkOutput("sim_speed_reset", speed, 1'b0);
    applyStimulus(1'b1, 1'b1, 7);
    checkOutput("sim_en_pulse", en_pulse, 1'b1);
    checkOutput("sim_speed_pulse", speed_pulse, 1'b1);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("sim_en", en, 1'b1);
    checkOutput("sim_speed", speed, 1'b1);
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b0, 12);

    // Reset at edge t0+4 while btn_en is held
    applyStimulus(1'b1, 1'b0, 4);
    checkOutput("midrst_no_pulse", en_pulse, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1);
    rst = 1'b0;
    checkOutput("midrst_en_cleared", en, 1'b0);
    checkOutput("midrst_speed_cleared", speed, 1'b0);
    applyStimulus(1'b1, 1'b0, 6);
    checkOutput("midrst_no_early_pulse", en_pulse, 1'b0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("midrst_pulse", en_pulse, 1'b1);
    checkOutput("midrst_en_before_flip", en, 1'b0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("midrst_en_flip", en, 1'b1);
    applyStimulus(1'b0, 1'b0, 12);

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
